// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback front end.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer of long-latency writebacks. Besides push/pop it
// compares every live entry's destination against the two decode source
// addresses, so decode can see that a register still has a queued write.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  wb_entry_t         push_entry_i,
    input  logic              pop_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    output wb_entry_t         head_o,
    output logic [CW-1:0]     count_o,
    output logic [DEPTH-1:0]  match1_o,
    output logic [DEPTH-1:0]  match2_o
);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Next-state for storage, pointers and occupancy; full/empty guards keep
    // a misbehaving caller from corrupting the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && (count_q < CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset simply forgets whatever was queued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset since the count decides what is live.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // An entry is live when its distance from the read pointer is below the
    // count; the head being popped this cycle is still live here.
    always_comb begin
        logic [PW-1:0] offset;
        logic          live;
        offset   = '0;
        live     = 1'b0;
        match1_o = '0;
        match2_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PW'(i) - rd_ptr_q;
            live        = ({1'b0, offset} < count_q);
            match1_o[i] = live && (mem_q[i].rd == rs1_i);
            match2_o[i] = live && (mem_q[i].rd == rs2_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU and LSU writebacks onto the single register-file write port.
// ALU results normally win; LSU results wait in a FIFO and are forced through
// once they have lost arbitration too many cycles in a row. Also exposes
// forwarding (write on the port now) and pending (write still queued) lookups.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [4:0]               alu_rd_i,
    input  logic [31:0]              alu_data_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [4:0]               lsu_rd_i,
    input  logic [31:0]              lsu_data_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic                     fwd1_hit_o,
    output logic                     fwd2_hit_o,
    output logic [31:0]              fwd1_data_o,
    output logic [31:0]              fwd2_data_o,
    output logic                     pend1_o,
    output logic                     pend2_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              dataW_o,
    output logic [4:0]               rsW_o,
    output logic                     RegWEn_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    wb_entry_t         lsu_entry;
    wb_entry_t         fifo_head;
    logic [CW-1:0]     fifo_count;
    logic [DEPTH-1:0]  match1;
    logic [DEPTH-1:0]  match2;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_nonempty;
    logic              force_pop;
    logic              alu_win;

    logic [SW-1:0]     starve_q, starve_d;
    logic              regwen_q, regwen_d;
    logic [4:0]        rsw_q, rsw_d;
    logic [31:0]       dataw_q, dataw_d;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (fifo_push),
        .push_entry_i (lsu_entry),
        .pop_i        (fifo_pop),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .head_o       (fifo_head),
        .count_o      (fifo_count),
        .match1_o     (match1),
        .match2_o     (match2)
    );

    // Arbitration: a starved FIFO preempts the ALU; otherwise a real ALU write
    // wins and the FIFO head drains whenever the ALU has nothing to write
    // (including x0 requests, which are swallowed).
    always_comb begin
        fifo_nonempty  = (fifo_count != '0);
        force_pop      = fifo_nonempty && (starve_q == SW'(STARVE_MAX));
        alu_ready_o    = !rst_i && !force_pop;
        lsu_ready_o    = !rst_i && (fifo_count < CW'(DEPTH));
        alu_win        = !rst_i && !force_pop && alu_valid_i && (alu_rd_i != '0);
        fifo_pop       = !rst_i && fifo_nonempty && !alu_win;
        fifo_push      = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
        lsu_entry      = '0;
        lsu_entry.rd   = lsu_rd_i;
        lsu_entry.data = lsu_data_i;
    end

    // Starvation counter: counts consecutive cycles a non-empty FIFO loses,
    // saturating at the threshold so the force condition holds until a pop.
    always_comb begin
        starve_d = starve_q;
        if (!fifo_nonempty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Write-port stage: the winner is presented for exactly one cycle; with no
    // winner the enable drops and address/data keep their last values.
    always_comb begin
        regwen_d = 1'b0;
        rsw_d    = rsw_q;
        dataw_d  = dataw_q;
        if (alu_win) begin
            regwen_d = 1'b1;
            rsw_d    = alu_rd_i;
            dataw_d  = alu_data_i;
        end else if (fifo_pop) begin
            regwen_d = 1'b1;
            rsw_d    = fifo_head.rd;
            dataw_d  = fifo_head.data;
        end
    end

    // Registered arbiter state and write-port outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
            regwen_q <= 1'b0;
            rsw_q    <= '0;
            dataw_q  <= '0;
        end else begin
            starve_q <= starve_d;
            regwen_q <= regwen_d;
            rsw_q    <= rsw_d;
            dataw_q  <= dataw_d;
        end
    end

    // Decode lookups: x0 never hits or stalls; forwarding looks at the write
    // currently on the port, pending looks at everything still queued.
    always_comb begin
        fwd1_hit_o  = regwen_q && (rs1_i != '0) && (rsw_q == rs1_i);
        fwd2_hit_o  = regwen_q && (rs2_i != '0) && (rsw_q == rs2_i);
        fwd1_data_o = fwd1_hit_o ? dataw_q : '0;
        fwd2_data_o = fwd2_hit_o ? dataw_q : '0;
        pend1_o     = (rs1_i != '0) && (|match1);
        pend2_o     = (rs2_i != '0) && (|match2);
    end

    assign count_o  = fifo_count;
    assign RegWEn_o = regwen_q;
    assign rsW_o    = rsw_q;
    assign dataW_o  = dataw_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: a per-cycle vector table for the
// combinational outputs plus a queue of expected register-file writes that a
// monitor drains whenever the write port fires.
module tb_wb_write_arbiter;

    typedef struct {
        logic        aluValid;
        logic [4:0]  aluRd;
        logic [31:0] aluData;
        logic        lsuValid;
        logic [4:0]  lsuRd;
        logic [31:0] lsuData;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        expAluReady;
        logic        expLsuReady;
        logic [2:0]  expCount;
        logic        expWen;
        logic        expPend1;
        logic        expPend2;
        logic        expFwd1;
        logic        expFwd2;
        logic [31:0] expFwd1Data;
        logic [31:0] expFwd2Data;
        logic        pushWrite;
        logic [4:0]  wrRd;
        logic [31:0] wrData;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        aluValid;
    logic        aluReady;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        lsuValid;
    logic        lsuReady;
    logic [4:0]  lsuRd;
    logic [31:0] lsuData;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1Hit;
    logic        fwd2Hit;
    logic [31:0] fwd1Data;
    logic [31:0] fwd2Data;
    logic        pend1;
    logic        pend2;
    logic [2:0]  count;
    logic [31:0] dataW;
    logic [4:0]  rsW;
    logic        regWEn;

    int   compared   = 0;
    int   mismatched = 0;
    logic monitorEn  = 1'b0;
    wr_t  expQ[$];
    vec_t vecs[21];

    wb_write_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alu_valid_i (aluValid),
        .alu_ready_o (aluReady),
        .alu_rd_i    (aluRd),
        .alu_data_i  (aluData),
        .lsu_valid_i (lsuValid),
        .lsu_ready_o (lsuReady),
        .lsu_rd_i    (lsuRd),
        .lsu_data_i  (lsuData),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .fwd1_hit_o  (fwd1Hit),
        .fwd2_hit_o  (fwd2Hit),
        .fwd1_data_o (fwd1Data),
        .fwd2_data_o (fwd2Data),
        .pend1_o     (pend1),
        .pend2_o     (pend2),
        .count_o     (count),
        .dataW_o     (dataW),
        .rsW_o       (rsW),
        .RegWEn_o    (regWEn)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and log a failure line if it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive all request and lookup inputs for the coming cycle.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                 input logic [4:0] r1, input logic [4:0] r2);
        aluValid = av;
        aluRd    = ard;
        aluData  = ad;
        lsuValid = lv;
        lsuRd    = lrd;
        lsuData  = ld;
        rs1      = r1;
        rs2      = r2;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        expQ.push_back(w);
    endtask

    function automatic vec_t mkVec(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic ear, input logic elr, input logic [2:0] ec, input logic ew,
        input logic ep1, input logic ep2, input logic ef1, input logic ef2,
        input logic [31:0] ef1d, input logic [31:0] ef2d,
        input logic pw, input logic [4:0] wrd, input logic [31:0] wd);
        vec_t v;
        v.aluValid = av;  v.aluRd = ard;  v.aluData = ad;
        v.lsuValid = lv;  v.lsuRd = lrd;  v.lsuData = ld;
        v.rs1 = r1;       v.rs2 = r2;
        v.expAluReady = ear; v.expLsuReady = elr; v.expCount = ec; v.expWen = ew;
        v.expPend1 = ep1; v.expPend2 = ep2; v.expFwd1 = ef1; v.expFwd2 = ef2;
        v.expFwd1Data = ef1d; v.expFwd2Data = ef2d;
        v.pushWrite = pw; v.wrRd = wrd; v.wrData = wd;
        return v;
    endfunction

    // Scoreboard monitor: every port write must be the next expected one.
    always @(negedge clk) begin
        if (monitorEn && regWEn === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", rsW, dataW);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("write_rd", {27'd0, rsW}, {27'd0, e.rd});
                checkOutput("write_data", dataW, e.data);
            end
        end
    end

    initial begin
        // Cycle-by-cycle vectors: ALU single write, x0 drop, starvation force,
        // forwarding/pending lookups.
        vecs[0]  = mkVec(1,5,32'hDEADBEEF, 0,0,0,     5,0,  1,1,0,0, 0,0,0,0, 0,0, 1,5,32'hDEADBEEF);
        vecs[1]  = mkVec(0,0,0,            0,0,0,     5,5,  1,1,0,1, 0,0,1,1, 32'hDEADBEEF,32'hDEADBEEF, 0,0,0);
        vecs[2]  = mkVec(0,0,0,            0,0,0,     5,0,  1,1,0,0, 0,0,0,0, 0,0, 0,0,0);
        vecs[3]  = mkVec(1,0,32'h1,        1,0,32'h1, 0,0,  1,1,0,0, 0,0,0,0, 0,0, 0,0,0);
        vecs[4]  = mkVec(0,0,0,            0,0,0,     0,0,  1,1,0,0, 0,0,0,0, 0,0, 0,0,0);
        vecs[5]  = mkVec(1,10,32'hA0,      1,1,32'h11, 0,0, 1,1,0,0, 0,0,0,0, 0,0, 1,10,32'hA0);
        vecs[6]  = mkVec(1,10,32'hA1,      1,2,32'h12, 0,0, 1,1,1,1, 0,0,0,0, 0,0, 1,10,32'hA1);
        vecs[7]  = mkVec(1,10,32'hA2,      1,3,32'h13, 0,0, 1,1,2,1, 0,0,0,0, 0,0, 1,10,32'hA2);
        vecs[8]  = mkVec(1,10,32'hA3,      1,4,32'h14, 0,0, 1,1,3,1, 0,0,0,0, 0,0, 1,10,32'hA3);
        vecs[9]  = mkVec(1,10,32'hA4,      1,5,32'h15, 1,4, 0,0,4,1, 1,1,0,0, 0,0, 1,1,32'h11);
        vecs[10] = mkVec(1,10,32'hA4,      0,0,0,     1,2,  1,1,3,1, 0,1,1,0, 32'h11,0, 1,10,32'hA4);
        vecs[11] = mkVec(0,0,0,            0,0,0,     10,2, 1,1,3,1, 0,1,1,0, 32'hA4,0, 1,2,32'h12);
        vecs[12] = mkVec(0,0,0,            0,0,0,     3,0,  1,1,2,1, 1,0,0,0, 0,0, 1,3,32'h13);
        vecs[13] = mkVec(0,0,0,            0,0,0,     4,3,  1,1,1,1, 1,0,0,1, 0,32'h13, 1,4,32'h14);
        vecs[14] = mkVec(0,0,0,            0,0,0,     4,0,  1,1,0,1, 0,0,1,0, 32'h14,0, 0,0,0);
        vecs[15] = mkVec(0,0,0,            0,0,0,     0,0,  1,1,0,0, 0,0,0,0, 0,0, 0,0,0);
        vecs[16] = mkVec(1,9,32'h1234,     1,7,32'h77, 0,0, 1,1,0,0, 0,0,0,0, 0,0, 1,9,32'h1234);
        vecs[17] = mkVec(1,8,32'h88,       0,0,0,     7,9,  1,1,1,1, 1,0,0,1, 0,32'h1234, 1,8,32'h88);
        vecs[18] = mkVec(1,0,32'h5,        0,0,0,     0,8,  1,1,1,1, 0,0,0,1, 0,32'h88, 1,7,32'h77);
        vecs[19] = mkVec(0,0,0,            0,0,0,     7,0,  1,1,0,1, 0,0,1,0, 32'h77,0, 0,0,0);
        vecs[20] = mkVec(0,0,0,            0,0,0,     0,0,  1,1,0,0, 0,0,0,0, 0,0, 0,0,0);

        // Reset
        rst = 1'b1;
        applyStimulus(0,0,0, 0,0,0, 0,0);
        #1;
        checkOutput("rst_alu_ready", {31'd0, aluReady}, 32'd0);
        checkOutput("rst_lsu_ready", {31'd0, lsuReady}, 32'd0);
        step();
        step();
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        checkOutput("rst_wen", {31'd0, regWEn}, 32'd0);
        checkOutput("rst_rsw", {27'd0, rsW}, 32'd0);
        checkOutput("rst_dataw", dataW, 32'd0);
        rst = 1'b0;
        monitorEn = 1'b1;

        // Table-driven section
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].aluValid, vecs[i].aluRd, vecs[i].aluData,
                          vecs[i].lsuValid, vecs[i].lsuRd, vecs[i].lsuData,
                          vecs[i].rs1, vecs[i].rs2);
            if (vecs[i].pushWrite) expectWrite(vecs[i].wrRd, vecs[i].wrData);
            #1;
            checkOutput($sformatf("v%0d_alu_ready", i), {31'd0, aluReady}, {31'd0, vecs[i].expAluReady});
            checkOutput($sformatf("v%0d_lsu_ready", i), {31'd0, lsuReady}, {31'd0, vecs[i].expLsuReady});
            checkOutput($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].expCount});
            checkOutput($sformatf("v%0d_wen", i), {31'd0, regWEn}, {31'd0, vecs[i].expWen});
            checkOutput($sformatf("v%0d_pend1", i), {31'd0, pend1}, {31'd0, vecs[i].expPend1});
            checkOutput($sformatf("v%0d_pend2", i), {31'd0, pend2}, {31'd0, vecs[i].expPend2});
            checkOutput($sformatf("v%0d_fwd1_hit", i), {31'd0, fwd1Hit}, {31'd0, vecs[i].expFwd1});
            checkOutput($sformatf("v%0d_fwd2_hit", i), {31'd0, fwd2Hit}, {31'd0, vecs[i].expFwd2});
            checkOutput($sformatf("v%0d_fwd1_data", i), fwd1Data, vecs[i].expFwd1Data);
            checkOutput($sformatf("v%0d_fwd2_data", i), fwd2Data, vecs[i].expFwd2Data);
            step();
        end

        // Simultaneous push and pop keeps occupancy; drain order x1,x2,x3.
        applyStimulus(1,20,32'h201, 1,1,32'h101, 0,0);
        expectWrite(20, 32'h201);
        step();
        applyStimulus(1,20,32'h202, 1,2,32'h102, 0,0);
        expectWrite(20, 32'h202);
        step();
        applyStimulus(0,0,0, 1,3,32'h103, 0,0);
        expectWrite(1, 32'h101);
        #1;
        checkOutput("pushpop_count_before", {29'd0, count}, 32'd2);
        step();
        checkOutput("pushpop_count_after", {29'd0, count}, 32'd2);
        applyStimulus(0,0,0, 0,0,0, 0,0);
        expectWrite(2, 32'h102);
        step();
        expectWrite(3, 32'h103);
        step();
        step();
        checkOutput("pushpop_drained", {29'd0, count}, 32'd0);

        // Reset with three queued entries: they must never reach the port.
        applyStimulus(1,21,32'h211, 1,11,32'h111, 0,0);
        expectWrite(21, 32'h211);
        step();
        applyStimulus(1,21,32'h212, 1,12,32'h112, 0,0);
        expectWrite(21, 32'h212);
        step();
        applyStimulus(1,21,32'h213, 1,13,32'h113, 0,0);
        expectWrite(21, 32'h213);
        step();
        checkOutput("midrst_count_before", {29'd0, count}, 32'd3);
        rst = 1'b1;
        applyStimulus(0,0,0, 0,0,0, 11,12);
        #1;
        checkOutput("midrst_alu_ready", {31'd0, aluReady}, 32'd0);
        checkOutput("midrst_lsu_ready", {31'd0, lsuReady}, 32'd0);
        step();
        rst = 1'b0;
        checkOutput("midrst_count", {29'd0, count}, 32'd0);
        checkOutput("midrst_wen", {31'd0, regWEn}, 32'd0);
        #1;
        checkOutput("midrst_pend1", {31'd0, pend1}, 32'd0);
        for (int i = 0; i < 6; i++) step();
        checkOutput("midrst_count_later", {29'd0, count}, 32'd0);

        // Normal operation resumes after reset.
        applyStimulus(1,6,32'h66, 0,0,0, 0,0);
        expectWrite(6, 32'h66);
        step();
        applyStimulus(0,0,0, 0,0,0, 0,0);
        step();
        step();

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
